// File: rtl/excl_grant_sched.sv
// Grant scheduler: A gets the resource alone, B/C share it, with
// alternating priority and a programmable dead time between owners.
module excl_grant_sched #(
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       req_c,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       gnt_c,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHARED = 2'd1,
        EXCL   = 2'd2,
        TURN   = 2'd3
    } state_e;

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_prio_q, a_prio_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       gnt_c_q, gnt_c_d;

    logic rd_req;
    logic pick_excl;
    logic pick_shared;

    // Ownership decision shared by IDLE and the end of TURN
    assign rd_req      = req_b | req_c;
    assign pick_excl   = req_a & (~rd_req | a_prio_q);
    assign pick_shared = rd_req & ~pick_excl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            a_prio_q <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            gnt_c_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_prio_q <= a_prio_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            gnt_c_q  <= gnt_c_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_prio_d = a_prio_q;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        gnt_c_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_excl) begin
                    state_d = EXCL;
                    gnt_a_d = 1'b1;
                end else if (pick_shared) begin
                    state_d = SHARED;
                    gnt_b_d = req_b;
                    gnt_c_d = req_c;
                end
            end
            EXCL: begin
                if (req_a) begin
                    gnt_a_d = 1'b1;
                end else begin
                    a_prio_d = 1'b0;
                    if (rd_req) begin
                        state_d = TURN;
                        cnt_d   = TURN_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SHARED: begin
                // A pending blocks new readers; granted ones drain
                gnt_b_d = req_b & (gnt_b_q | ~req_a);
                gnt_c_d = req_c & (gnt_c_q | ~req_a);
                if (!gnt_b_d && !gnt_c_d) begin
                    a_prio_d = 1'b1;
                    if (req_a) begin
                        state_d = TURN;
                        cnt_d   = TURN_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TURN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (pick_excl) begin
                    state_d = EXCL;
                    gnt_a_d = 1'b1;
                end else if (pick_shared) begin
                    state_d = SHARED;
                    gnt_b_d = req_b;
                    gnt_c_d = req_c;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign gnt_c = gnt_c_q;
    assign mode  = state_q;

endmodule
